// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Parametrised UART transmitter with an input FIFO. Frames are
//               DATA_W bits LSB first with optional odd/even parity and one or
//               two stop bits. Frames queued in the FIFO go out back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4,
    parameter int DIV_WID = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DIV_WID-1:0] i_div,
    input  logic [1:0]         i_parity,
    input  logic               i_stop2,
    input  logic               i_wr_en,
    input  logic [DATA_W-1:0]  i_wr_data,
    output logic               o_full,
    output logic [FIFO_AW:0]   o_level,
    output logic               o_overflow,
    output logic               o_txempty,
    output logic               o_uart_tx
);

    localparam int unsigned      c_DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam int               c_BCW      = $clog2(DATA_W);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_overflow;

    // Transmitter state
    logic [2:0]         r_state;
    logic               r_arm;
    logic               r_tx;
    logic [DIV_WID-1:0] r_div_cnt;
    logic [c_BCW-1:0]   r_bit_cnt;
    logic [DIV_WID-1:0] r_div;
    logic [1:0]         r_par;
    logic               r_stop2;
    logic [DATA_W-1:0]  r_word;
    logic [DATA_W-1:0]  r_shift;

    logic               w_wr_acc;
    logic               w_pop;
    logic               w_stop_last;
    logic [DATA_W-1:0]  w_head;
    logic               w_par_on;
    logic               w_par_bit;

    assign o_full     = (r_level == c_LVL_FULL);
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_txempty  = (r_level == '0) && (r_state == c_IDLE);
    assign o_uart_tx  = r_tx;

    assign w_wr_acc    = i_wr_en & ~o_full;
    assign w_head      = r_mem[r_rptr];
    // Last clock of the final stop bit: the point where the next word may be
    // pulled so its start bit follows without an idle gap.
    assign w_stop_last = (r_state == c_STOP) && (r_div_cnt == '0) && (r_bit_cnt == '0);
    assign w_pop       = (r_level != '0) && ((r_state == c_IDLE) || w_stop_last);
    // Parity codes 01 (odd) and 10 (even) enable the parity bit; 00/11 disable it.
    assign w_par_on    = r_par[0] ^ r_par[1];
    assign w_par_bit   = (r_par == 2'b01) ? ~^r_word : ^r_word;

    // FIFO storage write port (no reset needed on the data array)
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_overflow <= i_wr_en & o_full;
        end
    end

    // Frame sequencer: drives the registered serial line bit by bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= c_IDLE;
            r_arm     <= 1'b0;
            r_tx      <= 1'b1;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_div     <= '0;
            r_par     <= '0;
            r_stop2   <= 1'b0;
            r_word    <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // Pull a word; the start bit goes out on the following edge.
                    if (w_pop) begin
                        r_word  <= w_head;
                        r_div   <= i_div;
                        r_par   <= i_parity;
                        r_stop2 <= i_stop2;
                        r_arm   <= 1'b1;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (r_arm) begin
                        r_arm     <= 1'b0;
                        r_tx      <= 1'b0;
                        r_div_cnt <= r_div;
                    end else if (r_div_cnt == '0) begin
                        r_tx      <= r_word[0];
                        r_shift   <= r_word >> 1;
                        r_bit_cnt <= '0;
                        r_div_cnt <= r_div;
                        r_state   <= c_DATA;
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_div_cnt == '0) begin
                        r_div_cnt <= r_div;
                        if (r_bit_cnt == c_BCW'(DATA_W - 1)) begin
                            if (w_par_on) begin
                                r_tx    <= w_par_bit;
                                r_state <= c_PARITY;
                            end else begin
                                r_tx      <= 1'b1;
                                r_bit_cnt <= c_BCW'(r_stop2);
                                r_state   <= c_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                c_PARITY: begin
                    if (r_div_cnt == '0) begin
                        r_tx      <= 1'b1;
                        r_div_cnt <= r_div;
                        r_bit_cnt <= c_BCW'(r_stop2);
                        r_state   <= c_STOP;
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                c_STOP: begin
                    // r_bit_cnt holds the number of stop bits still to follow.
                    if (r_div_cnt == '0) begin
                        if (r_bit_cnt != '0) begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            r_div_cnt <= r_div;
                        end else if (w_pop) begin
                            r_word    <= w_head;
                            r_div     <= i_div;
                            r_par     <= i_parity;
                            r_stop2   <= i_stop2;
                            r_tx      <= 1'b0;
                            r_div_cnt <= i_div;
                            r_state   <= c_START;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Randomised self-checking bench for uart_tx_fifo. A frame-level
//               reference model (word queue + frame start/end times) predicts
//               the serial line and FIFO flags every clock.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic [15:0] div   = 16'd3;
    logic [1:0]  par   = 2'b00;
    logic        stop2 = 1'b0;
    logic        wr    = 1'b0;
    logic [7:0]  wdata = '0;
    logic        full, ovf, txempty, tx;
    logic [AW:0] level;

    logic [15:0] div7   = 16'd433;
    logic        wr7    = 1'b0;
    logic [6:0]  wdata7 = '0;
    logic        full7, ovf7, txe7, tx7;
    logic [AW:0] level7;

    uart_tx_fifo #(.DATA_W(DW), .FIFO_AW(AW), .DIV_WID(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_div(div), .i_parity(par), .i_stop2(stop2),
        .i_wr_en(wr), .i_wr_data(wdata), .o_full(full), .o_level(level),
        .o_overflow(ovf), .o_txempty(txempty), .o_uart_tx(tx)
    );

    uart_tx_fifo #(.DATA_W(7), .FIFO_AW(AW), .DIV_WID(16)) u_dut7 (
        .i_clk(clk), .i_rst(rst), .i_div(div7), .i_parity(2'b10), .i_stop2(1'b0),
        .i_wr_en(wr7), .i_wr_data(wdata7), .o_full(full7), .o_level(level7),
        .o_overflow(ovf7), .o_txempty(txe7), .o_uart_tx(tx7)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc      = 0;
    int unsigned mq[$];
    int          end_edge = -1;
    int          cur_s    = -1;
    int          cur_div  = 0;
    int          cur_nsym = 0;
    logic        cur_sym [0:11];
    logic        exp_ovf  = 1'b0;

    function automatic logic exp_line(input int k);
        int i;
        if (cur_s < 0 || k < cur_s) return 1'b1;
        i = (k - cur_s) / (cur_div + 1);
        if (i < cur_nsym) return cur_sym[i];
        return 1'b1;
    endfunction

    task automatic start_frame(input int s, input int unsigned wv);
        logic [7:0] w;
        int p;
        w = wv[7:0];
        p = (par == 2'b01 || par == 2'b10) ? 1 : 0;
        cur_s    = s;
        cur_div  = int'(div);
        cur_nsym = 1 + DW + p + (stop2 ? 2 : 1);
        for (int i = 0; i < 12; i++) cur_sym[i] = 1'b1;
        cur_sym[0] = 1'b0;
        for (int b = 0; b < DW; b++) cur_sym[1 + b] = w[b];
        if (p == 1) cur_sym[1 + DW] = (par == 2'b10) ? ^w : ~^w;
        end_edge = s + cur_nsym * (cur_div + 1);
    endtask

    // One clock: apply inputs, advance model for the coming edge, check after it.
    task automatic step(input logic r, input logic w, input logic [7:0] d);
        int  k;
        logic full_pre;
        rst = r; wr = w; wdata = d;
        k = cyc + 1;
        if (r) begin
            mq.delete();
            end_edge = -1;
            cur_s    = -1;
            exp_ovf  = 1'b0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            exp_ovf  = w && full_pre;
            if (end_edge == k) begin
                if (mq.size() > 0) start_frame(k, mq.pop_front());
                else end_edge = -1;
            end else if (end_edge < 0 && mq.size() > 0) begin
                start_frame(k + 1, mq.pop_front());
            end
            if (w && !full_pre) mq.push_back(int'(d));
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("level",    level,   mq.size());
        check("full",     full,    mq.size() == DEPTH);
        check("overflow", ovf,     exp_ovf);
        check("txempty",  txempty, end_edge < 0 && mq.size() == 0);
        check("line",     tx,      exp_line(k));
    endtask

    task automatic drain();
        int guard = 0;
        while (!(end_edge < 0 && mq.size() == 0) && guard < 20000) begin
            step(1'b0, 1'b0, 8'h00);
            guard++;
        end
        check("drain_timeout", guard >= 20000, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int ocnt;
        int target;
        int s6;
        logic [6:0] w7;
        logic       sym7 [0:9];

        @(negedge clk);
        repeat (3) step(1'b1, 1'b0, 8'h00);
        check("rst_tx7", tx7, 1'b1);
        check("rst_txe7", txe7, 1'b1);

        // T1: 8N1, div 3, 0x55
        div = 16'd3; par = 2'b00; stop2 = 1'b0;
        step(1'b0, 1'b1, 8'h55);
        drain();

        // T2: even / odd parity on 0x07, then two stop bits
        par = 2'b10; step(1'b0, 1'b1, 8'h07); drain();
        par = 2'b01; step(1'b0, 1'b1, 8'h07); drain();
        par = 2'b00; stop2 = 1'b1; step(1'b0, 1'b1, 8'hC3); drain();
        stop2 = 1'b0;

        // T3: three consecutive writes go out contiguous
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
        drain();

        // T4: fill while busy, one write dropped with a single overflow pulse
        step(1'b0, 1'b1, 8'hA0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        ocnt = 0;
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 8'(8'h10 + i));
            if (ovf) ocnt++;
        end
        check("t4_full", full, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        if (ovf) ocnt++;
        check("t4_ovf_count", ocnt, 1);
        drain();

        // T5: reset during data bit 3, then a clean frame
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b0, 8'h00);
        target = cur_s + 4 * (cur_div + 1) + 1;
        while (cyc + 1 < target) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("t5_tx_high", tx, 1'b1);
        check("t5_level0", level, 0);
        step(1'b0, 1'b1, 8'h96);
        drain();

        // Random traffic with random configuration changes and rare resets
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 30) == 0) begin
                div   = 16'($urandom_range(0, 4));
                par   = 2'($urandom_range(0, 3));
                stop2 = 1'($urandom_range(0, 1));
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
        end
        drain();

        // T6: 7E1 at div 433 on the 7-bit instance, divisor changed mid-frame
        w7 = 7'h41;
        sym7[0] = 1'b0;
        for (int b = 0; b < 7; b++) sym7[1 + b] = w7[b];
        sym7[8] = ^w7;
        sym7[9] = 1'b1;
        wr7 = 1'b1; wdata7 = w7;
        step(1'b0, 1'b0, 8'h00);
        wr7 = 1'b0;
        s6 = cyc + 2;
        while (cyc < s6 + 4340) begin
            if (cyc == s6 + 100) div7 = 16'd5;
            step(1'b0, 1'b0, 8'h00);
            if (cyc == s6 - 1) check("t6_pre_start", tx7, 1'b1);
            if (cyc >= s6 && cyc < s6 + 4340) begin
                if ((cyc - s6) % 434 == 0 || (cyc - s6) % 434 == 433)
                    check("t6_bit", tx7, sym7[(cyc - s6) / 434]);
                if (cyc == s6 + 4339) check("t6_busy", txe7, 1'b0);
            end
        end
        check("t6_end_line", tx7, 1'b1);
        check("t6_end_txempty", txe7, 1'b1);
        check("t6_level", level7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
